// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter
// Shares the single fb_controller command port between one scanout read
// requester and N_WR pixel-writer requesters. Each grant issues one command
// strobe, waits for fb_controller done (or a timeout), returns a one-cycle
// acknowledge and re-arbitrates. Reads have priority, limited by a write
// starvation counter; writers are served round-robin.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_wr_req  [N_WR]        per-writer request, held until its ack
//   i_wr_x/y  [N_WR*16]     packed writer coordinates, writer i at [16i+:16]
//   i_wr_rgb  [N_WR*32]     packed writer pixel data, writer i at [32i+:32]
//   o_wr_ack  [N_WR]        one-cycle one-hot write completion
//   i_rd_req                scanout read request, held until o_rd_ack
//   i_rd_x/y  [16]          read coordinates
//   o_rd_ack                one-cycle read completion
//   o_rd_rgb  [32]          read data, valid with o_rd_ack and held after
//   o_err                   pulses with an ack when the transaction timed out
//   o_do_read/o_do_write    one-cycle command strobes to fb_controller
//   o_pix_x/y [16]          command coordinates
//   o_write_rgb [32]        command write data
//   i_read_rgb [32]         read data from fb_controller
//   i_busy, i_done          fb_controller status, done is a one-cycle pulse
// ---------------------------------------------------------------------------
module fb_arbiter #(
  parameter int unsigned N_WR       = 4,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_WR-1:0]      i_wr_req,
  input  logic [N_WR*16-1:0]   i_wr_x,
  input  logic [N_WR*16-1:0]   i_wr_y,
  input  logic [N_WR*32-1:0]   i_wr_rgb,
  output logic [N_WR-1:0]      o_wr_ack,
  input  logic                 i_rd_req,
  input  logic [15:0]          i_rd_x,
  input  logic [15:0]          i_rd_y,
  output logic                 o_rd_ack,
  output logic [31:0]          o_rd_rgb,
  output logic                 o_err,
  output logic                 o_do_read,
  output logic                 o_do_write,
  output logic [15:0]          o_pix_x,
  output logic [15:0]          o_pix_y,
  output logic [31:0]          o_write_rgb,
  input  logic [31:0]          i_read_rgb,
  input  logic                 i_busy,
  input  logic                 i_done
);

  localparam int unsigned IDX_W  = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int unsigned TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned SCNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_gnt_rd;
  logic [IDX_W-1:0]    r_gnt_idx;
  logic [IDX_W-1:0]    r_last_wr;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [SCNT_W-1:0]   r_starve;
  logic [N_WR-1:0]     r_wr_ack;
  logic                r_rd_ack;
  logic [31:0]         r_rd_rgb;
  logic                r_err;
  logic                r_do_read;
  logic                r_do_write;
  logic [15:0]         r_pix_x;
  logic [15:0]         r_pix_y;
  logic [31:0]         r_write_rgb;

  logic                w_wr_found;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [IDX_W-1:0]    w_cand;
  logic [15:0]         w_sel_x;
  logic [15:0]         w_sel_y;
  logic [31:0]         w_sel_rgb;
  logic                w_starved;
  logic                w_pick_wr;
  logic                w_grant;
  logic                w_timed_out;

  // Round-robin search starting at last_wr+1. Scanning from the farthest
  // candidate down lets the nearest requesting index overwrite the result.
  always_comb begin
    w_wr_found = 1'b0;
    w_wr_idx   = '0;
    w_cand     = '0;
    for (int k = int'(N_WR); k >= 1; k--) begin
      w_cand = IDX_W'((32'(r_last_wr) + 32'(k)) % N_WR);
      if (i_wr_req[w_cand]) begin
        w_wr_found = 1'b1;
        w_wr_idx   = w_cand;
      end
    end
  end

  // Field mux for the round-robin winner.
  always_comb begin
    w_sel_x   = '0;
    w_sel_y   = '0;
    w_sel_rgb = '0;
    for (int i = 0; i < int'(N_WR); i++) begin
      if (w_wr_idx == IDX_W'(i)) begin
        w_sel_x   = i_wr_x[16*i +: 16];
        w_sel_y   = i_wr_y[16*i +: 16];
        w_sel_rgb = i_wr_rgb[32*i +: 32];
      end
    end
  end

  // A writer wins when no read is pending or reads have hit the starvation cap.
  assign w_starved   = (r_starve == SCNT_W'(STARVE_MAX));
  assign w_pick_wr   = w_wr_found && (!i_rd_req || w_starved);
  assign w_grant     = !i_busy && (i_rd_req || w_wr_found);
  assign w_timed_out = (r_tcnt == TCNT_W'(TIMEOUT));

  // Transaction sequencer with registered strobes, acks and command fields.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_gnt_rd    <= 1'b0;
      r_gnt_idx   <= '0;
      r_last_wr   <= IDX_W'(N_WR - 1);
      r_tcnt      <= '0;
      r_starve    <= '0;
      r_wr_ack    <= '0;
      r_rd_ack    <= 1'b0;
      r_rd_rgb    <= '0;
      r_err       <= 1'b0;
      r_do_read   <= 1'b0;
      r_do_write  <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_write_rgb <= '0;
    end else begin
      // Strobes and acks are single-cycle pulses.
      r_do_read  <= 1'b0;
      r_do_write <= 1'b0;
      r_wr_ack   <= '0;
      r_rd_ack   <= 1'b0;
      r_err      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state <= S_CMD;
            r_tcnt  <= '0;
            if (w_pick_wr) begin
              r_gnt_rd    <= 1'b0;
              r_gnt_idx   <= w_wr_idx;
              r_last_wr   <= w_wr_idx;
              r_starve    <= '0;
              r_do_write  <= 1'b1;
              r_pix_x     <= w_sel_x;
              r_pix_y     <= w_sel_y;
              r_write_rgb <= w_sel_rgb;
            end else begin
              r_gnt_rd  <= 1'b1;
              r_do_read <= 1'b1;
              r_pix_x   <= i_rd_x;
              r_pix_y   <= i_rd_y;
              // Only reads that bypass a waiting writer count toward starvation.
              r_starve  <= w_wr_found ? (r_starve + SCNT_W'(1)) : '0;
            end
          end
        end

        S_CMD, S_WAIT: begin
          if (i_done || w_timed_out) begin
            r_state  <= S_ACK;
            r_rd_ack <= r_gnt_rd;
            r_wr_ack <= r_gnt_rd ? '0 : (N_WR'(1) << r_gnt_idx);
            // done takes precedence over a coincident timeout.
            r_err    <= !i_done;
            if (r_gnt_rd && i_done) begin
              r_rd_rgb <= i_read_rgb;
            end
          end else begin
            r_state <= S_WAIT;
            r_tcnt  <= r_tcnt + TCNT_W'(1);
          end
        end

        S_ACK: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_wr_ack    = r_wr_ack;
  assign o_rd_ack    = r_rd_ack;
  assign o_rd_rgb    = r_rd_rgb;
  assign o_err       = r_err;
  assign o_do_read   = r_do_read;
  assign o_do_write  = r_do_write;
  assign o_pix_x     = r_pix_x;
  assign o_pix_y     = r_pix_y;
  assign o_write_rgb = r_write_rgb;

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Arbitrates the single framebuffer command port of `fb_controller` between one HDMI scanout read requester and `N_WR` Mandelbrot pixel-writer requesters. It sequences each granted request as one command strobe, waits for `fb_controller`'s `done`, returns an acknowledge, and then re-arbitrates. Reads have priority, bounded by a write-starvation limit. Writers share round-robin. A watchdog aborts transactions that never complete.

## Interface
- `N_WR`, 4: number of writer ports, 1..8.
- `STARVE_MAX`, 8: maximum consecutive read grants while any write is pending.
- `TIMEOUT`, 1024: cycles to wait for `done` before aborting.
- `clk`  in  1: single clock; all logic rises on the posedge.
- `rst`  in  1: asynchronous, active-high reset.
- `wr_req`  in  `N_WR`: per-writer request; held high until `wr_ack` is seen.
- `wr_x`, `wr_y`  in  `N_WR*16`: packed coordinates; writer i uses slice [16i+15:16i].
- `wr_rgb`  in  `N_WR*32`: packed pixel data.
- `wr_ack`  out  `N_WR`: one-cycle completion pulse, one-hot.
- `rd_req`  in  1: scanout read request; held until `rd_ack`.
- `rd_x`, `rd_y`  in  16: read coordinates.
- `rd_ack`  out  1: one-cycle read completion pulse.
- `rd_rgb`  out  32: read data; valid when `rd_ack` is high and held afterwards.
- `err`  out  1: pulses together with an ack when the transaction timed out.
- `do_read`, `do_write`  out  1: one-cycle command strobes to `fb_controller`.
- `pix_x`, `pix_y`  out  16: command coordinates.
- `write_rgb`  out  32: command write data.
- `read_rgb`  in  32: read data from `fb_controller`.
- `busy`, `done`  in  1: `fb_controller` status; `done` is a one-cycle completion pulse.

## Operation
- **FSM:** `IDLE` -> `CMD` -> `WAIT` -> `ACK` -> `IDLE`. All outputs are registered.
- **`IDLE`:**
  - Arbitrates only when `busy`=0 and at least one request is high.
  - Latches the winner's x/y/rgb into `pix_x`/`pix_y`/`write_rgb`, latches the grant identity, and goes to `CMD`.
  - `write_rgb` is left unchanged for a read grant.
- **`CMD`:** exactly one of `do_read`/`do_write` is high for this single cycle. `done` sampled here counts as completion.
- **`WAIT`:**
  - On `done`=1, go to `ACK`.
  - Timeout counter is cleared on entry to `CMD` and increments each `CMD`/`WAIT` cycle.
  - When the counter reaches `TIMEOUT` without `done`, go to `ACK` with `err` pending.
- **`ACK`:**
  - The granted `wr_ack[i]` or `rd_ack` is high for this one cycle, with `err` if timed out.
  - For a successful read, `rd_rgb` takes the value of `read_rgb` sampled on the `done` cycle.
  - A timed-out read leaves `rd_rgb` unchanged.
  - Write completions never alter `rd_rgb`.
- **Requester rule:** drop `req`, or present new data with `req` still high, at the edge after `ack`. The arbiter never samples requests in `ACK`, so the same requester cannot be double-granted.
- **Priority:**
  - `rd_req` wins unless the starvation counter equals `STARVE_MAX` and some `wr_req` is high; in that case a writer wins.
  - The starvation counter increments on each read grant made while any `wr_req` is high.
  - It clears on any write grant, or on a read grant made with no write pending.
- **Writer round-robin:**
  - Search from `last_wr+1` modulo `N_WR`. The first requesting index wins.
  - `last_wr` updates only on a write grant.
- **Spurious signals:** `done` in `IDLE`/`ACK` is ignored. Request changes after the grant are ignored, because the fields are latched.
- **Reset:**
  - FSM `IDLE`.
  - All strobes, acks and `err` 0.
  - `pix_x`, `pix_y`, `write_rgb`, `rd_rgb` 0.
  - Starvation counter 0 and timeout counter 0.
  - `last_wr` = `N_WR-1`, so writer 0 is first.
- **Reset mid-transaction:** the transaction is abandoned with no ack.

## Timing
- A request high at edge k in `IDLE` gives a strobe during cycle k+1.
- Minimum transaction is 3 cycles (`IDLE`, `CMD`, `ACK`) when `done` arrives in `CMD`.
- `done` sampled at edge d gives the ack during cycle d+1, then `IDLE` at d+2.
- Back-to-back grants are separated by at least 3 cycles (strobe-to-strobe).
- A timeout ack appears `TIMEOUT`+1 cycles after the strobe cycle.
- `busy`=1 in `IDLE` stalls the grant for every cycle it stays high.

## Test plan
- **Single write:** writer 2 requests x=100, y=200, rgb=AABBCCDD; `done` 3 cycles after `do_write`.
  - One `do_write` pulse with `pix_x`=100, `pix_y`=200, `write_rgb`=AABBCCDD.
  - `wr_ack`=0100 one cycle after `done`; `err`=0.
- **Single read:** read at (5,7); `read_rgb`=11223344 on the `done` cycle.
  - One `do_read` pulse.
  - `rd_ack` with `rd_rgb`=11223344, held after the pulse.
- **Round-robin:** all 4 writers hold requests and `done` is returned immediately.
  - Grant order 0,1,2,3,0.
  - Exactly one `wr_ack` per grant, never two in one cycle.
- **Starvation:** `rd_req` and `wr_req[1]` held continuously, `STARVE_MAX`=8.
  - 8 reads, then 1 write to writer 1, then 8 reads, repeating.
- **Timeout and `busy`:** with `TIMEOUT`=16, never send `done`.
  - The ack with `err`=1 arrives 17 cycles after the strobe.
  - Separately, holding `busy`=1 for 5 cycles delays the strobe by 5 cycles.
- **Reset mid-op:** assert `rst` during `WAIT`.
  - All outputs 0 immediately; no ack.
  - After release, writer 0 is granted first.
